// File: rtl/rv_lat_scoreboard_if.sv
// Decode-side and completion-side signals of the long-latency register scoreboard.
// The pipeline drives through "master"; the scoreboard receives through "slave".
interface rv_lat_scoreboard_if #(
    parameter int NUM_REGS  = 32,
    parameter int ADDR_W    = 5,
    parameter int NUM_UNITS = 2,
    parameter int UNIT_W    = 1
);
    logic                        id_valid;
    logic [ADDR_W-1:0]           id_rs1;
    logic [ADDR_W-1:0]           id_rs2;
    logic                        id_rs1_used;
    logic                        id_rs2_used;
    logic [ADDR_W-1:0]           id_rd;
    logic                        id_rd_wena;
    logic                        id_long;
    logic [UNIT_W-1:0]           id_unit;
    logic                        flush;
    logic [NUM_UNITS-1:0]        cpl_valid;
    logic                        id_stall;
    logic                        issue;
    logic [NUM_REGS-1:0]         pending;
    logic [NUM_UNITS-1:0]        unit_busy;
    logic [NUM_UNITS*ADDR_W-1:0] cpl_waddr;
    logic                        err;
    logic [1:0]                  err_code;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_wena,
               id_long, id_unit, flush, cpl_valid,
        input  id_stall, issue, pending, unit_busy, cpl_waddr, err, err_code
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_wena,
               id_long, id_unit, flush, cpl_valid,
        output id_stall, issue, pending, unit_busy, cpl_waddr, err, err_code
    );
endinterface

// File: rtl/rv_lat_scoreboard.sv
// Register scoreboard and stall generator for variable/long-latency execute units.
// Tracks outstanding long writes per register, stalls RAW/WAW/structural hazards, watchdogs each unit.
module rv_lat_scoreboard #(
    parameter int NUM_REGS  = 32,
    parameter int ADDR_W    = 5,
    parameter int NUM_UNITS = 2,
    parameter int UNIT_W    = 1,
    parameter int TIMEOUT   = 64
) (
    input logic               clk,
    input logic               rst,
    rv_lat_scoreboard_if.slave sb
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    logic [NUM_REGS-1:0]                pending_q;
    logic [NUM_REGS-1:0]                set_mask;
    logic [NUM_REGS-1:0]                clr_mask;
    logic [NUM_UNITS-1:0][NUM_REGS-1:0] clr_vecs;
    logic [NUM_UNITS-1:0]               busy_w;
    logic [NUM_UNITS-1:0]               tmo_w;
    logic [NUM_UNITS-1:0]               spur_w;
    logic                               rs1_hit, rs2_hit, waw_hit, struct_hit;
    logic                               stall_w, issue_w;
    logic                               err_q;
    logic [1:0]                         err_code_q;

    // Hazards look only at registered state; x0 is never pending so it cannot hit.
    assign rs1_hit    = sb.id_rs1_used & (sb.id_rs1 != '0) & pending_q[sb.id_rs1];
    assign rs2_hit    = sb.id_rs2_used & (sb.id_rs2 != '0) & pending_q[sb.id_rs2];
    assign waw_hit    = sb.id_rd_wena  & (sb.id_rd  != '0) & pending_q[sb.id_rd];
    assign struct_hit = sb.id_long & busy_w[sb.id_unit];
    assign stall_w    = sb.id_valid & (rs1_hit | rs2_hit | waw_hit | struct_hit);
    assign issue_w    = sb.id_valid & ~stall_w & ~sb.flush;

    assign set_mask = (issue_w & sb.id_long & sb.id_rd_wena & (sb.id_rd != '0))
                    ? (NUM_REGS'(1) << sb.id_rd) : '0;

    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
        state_t            state_q, state_d;
        logic [ADDR_W-1:0] rd_q;
        logic              wena_q;
        logic [CNT_W-1:0]  cnt_q;
        logic [ADDR_W-1:0] waddr_q;
        logic              issue_u, cpl_hit, tmo_hit;

        assign issue_u = issue_w & sb.id_long & (sb.id_unit == UNIT_W'(u));
        assign cpl_hit = sb.cpl_valid[u] & (state_q == BUSY);

        if (TIMEOUT > 0) begin : g_wd
            // A completion landing on the last allowed cycle beats the watchdog.
            assign tmo_hit = (state_q == BUSY) & ~sb.cpl_valid[u] & (cnt_q == CNT_W'(TIMEOUT - 1));
        end else begin : g_nowd
            assign tmo_hit = 1'b0;
        end

        always_comb begin
            state_d = state_q;
            case (state_q)
                IDLE:    if (issue_u) state_d = BUSY;
                BUSY:    if (cpl_hit | tmo_hit) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q <= IDLE;
                rd_q    <= '0;
                wena_q  <= 1'b0;
                cnt_q   <= '0;
                waddr_q <= '0;
            end else begin
                state_q <= state_d;
                if (issue_u) begin
                    rd_q   <= sb.id_rd;
                    wena_q <= sb.id_rd_wena;
                    cnt_q  <= '0;
                end else if (state_q == BUSY) begin
                    cnt_q <= cnt_q + 1'b1;
                end
                if (cpl_hit) waddr_q <= rd_q;
            end
        end

        assign busy_w[u]   = (state_q == BUSY);
        assign tmo_w[u]    = tmo_hit;
        assign spur_w[u]   = sb.cpl_valid[u] & (state_q == IDLE);
        assign clr_vecs[u] = ((cpl_hit | tmo_hit) & wena_q & (rd_q != '0))
                           ? (NUM_REGS'(1) << rd_q) : '0;
        assign sb.cpl_waddr[u*ADDR_W +: ADDR_W] = waddr_q;
    end

    always_comb begin
        clr_mask = '0;
        for (int u = 0; u < NUM_UNITS; u++) clr_mask = clr_mask | clr_vecs[u];
    end

    // A new issue setting a bit outranks a completion clearing it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pending_q <= '0;
        else      pending_q <= (pending_q & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
        end else if (!err_q) begin
            if (|tmo_w) begin
                err_q      <= 1'b1;
                err_code_q <= 2'b01;
            end else if (|spur_w) begin
                err_q      <= 1'b1;
                err_code_q <= 2'b10;
            end
        end
    end

    assign sb.id_stall  = stall_w;
    assign sb.issue     = issue_w;
    assign sb.pending   = pending_q;
    assign sb.unit_busy = busy_w;
    assign sb.err       = err_q;
    assign sb.err_code  = err_code_q;
endmodule

// File: tb/tb_rv_lat_scoreboard.sv
// Directed plus random stimulus for rv_lat_scoreboard against an op-record reference model.
module tb_rv_lat_scoreboard;
    localparam int NR  = 32;
    localparam int AW  = 5;
    localparam int NU  = 2;
    localparam int UW  = 1;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rv_lat_scoreboard_if #(.NUM_REGS(NR), .ADDR_W(AW), .NUM_UNITS(NU), .UNIT_W(UW)) sb ();

    rv_lat_scoreboard #(.NUM_REGS(NR), .ADDR_W(AW), .NUM_UNITS(NU), .UNIT_W(UW), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: one record per unit describing the op in flight, if any.
    bit m_inflight [NU];
    int m_rd       [NU];
    bit m_wena     [NU];
    int m_iss      [NU];
    int m_waddr    [NU];
    bit m_err;
    int m_code;
    int cyc;

    function automatic void m_reset();
        for (int u = 0; u < NU; u++) begin
            m_inflight[u] = 0; m_rd[u] = 0; m_wena[u] = 0; m_iss[u] = 0; m_waddr[u] = 0;
        end
        m_err = 0; m_code = 0; cyc = 0;
    endfunction

    // A register is pending exactly when some in-flight op will write it.
    function automatic logic [NR-1:0] m_pending();
        logic [NR-1:0] p = '0;
        for (int u = 0; u < NU; u++)
            if (m_inflight[u] && m_wena[u] && m_rd[u] != 0) p[m_rd[u]] = 1'b1;
        return p;
    endfunction

    function automatic logic [NU-1:0] m_busy();
        logic [NU-1:0] b = '0;
        for (int u = 0; u < NU; u++) b[u] = m_inflight[u];
        return b;
    endfunction

    function automatic logic [NU*AW-1:0] m_waddr_vec();
        logic [NU*AW-1:0] w = '0;
        for (int u = 0; u < NU; u++) w[u*AW +: AW] = AW'(m_waddr[u]);
        return w;
    endfunction

    function automatic void m_update(input logic iss);
        bit tmo_any = 0, spur_any = 0;
        bit done [NU];
        for (int u = 0; u < NU; u++) begin
            done[u] = 0;
            if (sb.cpl_valid[u]) begin
                if (m_inflight[u]) begin m_waddr[u] = m_rd[u]; done[u] = 1; end
                else spur_any = 1;
            end else if (m_inflight[u] && (cyc - m_iss[u]) == TMO) begin
                tmo_any = 1; done[u] = 1;
            end
        end
        for (int u = 0; u < NU; u++) if (done[u]) m_inflight[u] = 0;
        if (!m_err && tmo_any) begin m_err = 1; m_code = 1; end
        else if (!m_err && spur_any) begin m_err = 1; m_code = 2; end
        if (iss && sb.id_long) begin
            m_inflight[int'(sb.id_unit)] = 1;
            m_rd[int'(sb.id_unit)]       = int'(sb.id_rd);
            m_wena[int'(sb.id_unit)]     = sb.id_rd_wena;
            m_iss[int'(sb.id_unit)]      = cyc;
        end
        cyc++;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                         input int rd, input bit we, input bit lg, input int unit, input bit fl,
                         input logic [NU-1:0] cpl);
        sb.id_valid = v;   sb.id_rs1 = AW'(rs1); sb.id_rs1_used = u1;
        sb.id_rs2 = AW'(rs2); sb.id_rs2_used = u2; sb.id_rd = AW'(rd);
        sb.id_rd_wena = we; sb.id_long = lg; sb.id_unit = UW'(unit);
        sb.flush = fl; sb.cpl_valid = cpl;
    endtask

    task automatic idle_in();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
    endtask

    // Inputs are driven just after the falling edge; one call covers one full cycle.
    task automatic tick();
        logic [NR-1:0] pm;
        logic raw, waw, st, exp_stall, exp_issue;
        #1;
        pm  = m_pending();
        raw = (sb.id_rs1_used && sb.id_rs1 != 0 && pm[sb.id_rs1]) ||
              (sb.id_rs2_used && sb.id_rs2 != 0 && pm[sb.id_rs2]);
        waw = sb.id_rd_wena && sb.id_rd != 0 && pm[sb.id_rd];
        st  = sb.id_long && m_inflight[int'(sb.id_unit)];
        exp_stall = sb.id_valid && (raw || waw || st);
        exp_issue = sb.id_valid && !exp_stall && !sb.flush;
        chk("id_stall", 64'(sb.id_stall), 64'(exp_stall));
        chk("issue", 64'(sb.issue), 64'(exp_issue));
        @(posedge clk);
        m_update(exp_issue);
        #1;
        chk("pending", 64'(sb.pending), 64'(m_pending()));
        chk("unit_busy", 64'(sb.unit_busy), 64'(m_busy()));
        chk("cpl_waddr", 64'(sb.cpl_waddr), 64'(m_waddr_vec()));
        chk("err", 64'(sb.err), 64'(m_err));
        chk("err_code", 64'(sb.err_code), 64'(m_code));
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".id_stall"}, 64'(sb.id_stall), 64'(0));
        chk({tag, ".issue"}, 64'(sb.issue), 64'(0));
        chk({tag, ".pending"}, 64'(sb.pending), 64'(0));
        chk({tag, ".unit_busy"}, 64'(sb.unit_busy), 64'(0));
        chk({tag, ".cpl_waddr"}, 64'(sb.cpl_waddr), 64'(0));
        chk({tag, ".err"}, 64'(sb.err), 64'(0));
        chk({tag, ".err_code"}, 64'(sb.err_code), 64'(0));
    endtask

    initial begin
        logic [NU-1:0] cpl;
        m_reset();
        idle_in();
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;

        // LW x5 on unit 0, dependent ADD x6,x5,x1 waits for the completion.
        drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, '0); tick();
        drive(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, '0); tick(); tick();
        chk("lw.stall_held", 64'(sb.id_stall), 64'(1));
        drive(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 2'b01); tick();
        chk("lw.waddr0", 64'(sb.cpl_waddr[4:0]), 64'(5));
        drive(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, '0);
        #1 chk("lw.add_issues", 64'(sb.issue), 64'(1));
        tick();

        // FFT x7 then LW x8: independent units, completions out of order.
        drive(1, 0, 0, 0, 0, 7, 1, 1, 1, 0, '0); tick();
        drive(1, 0, 0, 0, 0, 8, 1, 1, 0, 0, '0); tick();
        chk("two.pending", 64'(sb.pending), 64'((32'd1 << 7) | (32'd1 << 8)));
        idle_in(); sb.cpl_valid = 2'b01; tick();
        idle_in(); sb.cpl_valid = 2'b10; tick();
        chk("two.pending_clear", 64'(sb.pending), 64'(0));

        // Structural stall on the FFT unit, then WAW on x7.
        drive(1, 0, 0, 0, 0, 7, 1, 1, 1, 0, '0); tick();
        drive(1, 1, 1, 2, 1, 9, 1, 1, 1, 0, '0); tick(); tick();
        drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, '0); tick();
        chk("waw.stall", 64'(sb.id_stall), 64'(1));
        drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 2'b10); tick();
        drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, '0); tick();

        // Long op writing x0 leaves pending empty; ADD x1,x0,x0 does not stall.
        drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, '0); tick();
        chk("x0.pending", 64'(sb.pending), 64'(0));
        chk("x0.busy", 64'(sb.unit_busy[0]), 64'(1));
        drive(1, 0, 1, 0, 1, 1, 1, 0, 0, 0, '0); tick();
        idle_in(); sb.cpl_valid = 2'b01; tick();

        // Watchdog: eight busy cycles, then forced idle and err_code 01.
        drive(1, 0, 0, 0, 0, 12, 1, 1, 1, 0, '0); tick();
        idle_in();
        repeat (7) tick();
        chk("tmo.still_busy", 64'(sb.unit_busy[1]), 64'(1));
        tick();
        chk("tmo.busy", 64'(sb.unit_busy[1]), 64'(0));
        chk("tmo.pending", 64'(sb.pending[12]), 64'(0));
        chk("tmo.code", 64'(sb.err_code), 64'(1));
        sb.cpl_valid = 2'b10; tick();
        chk("tmo.code_sticky", 64'(sb.err_code), 64'(1));

        // Asynchronous reset with both units busy and flush asserted.
        drive(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, '0); tick();
        drive(1, 0, 0, 0, 0, 4, 1, 1, 1, 0, '0); tick();
        drive(1, 3, 1, 4, 1, 5, 1, 0, 0, 1, '0);
        #2 rst = 1'b0;
        #1 chk_all_zero("async_rst");
        m_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(1, 3, 1, 4, 1, 5, 1, 0, 0, 0, '0);
        #1 chk("post_rst.issue", 64'(sb.issue), 64'(1));
        tick();

        // Random traffic on a small register window to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            for (int u = 0; u < NU; u++)
                cpl[u] = m_inflight[u] ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
                  $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
                  $urandom_range(0, 1), $urandom_range(0, 9) < 3, $urandom_range(0, 1),
                  $urandom_range(0, 9) == 0, cpl);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rv_lat_scoreboard.md
# rv_lat_scoreboard

Parametrised register scoreboard and stall generator for the pipelined RISC-V core. It supports execute units whose latency is variable or longer than one cycle, such as loads from a slow memory or the FFT butterfly engine. It sits beside the decode stage and tracks which destination registers have a write outstanding from each long-latency unit. It stalls RAW, WAW and structural hazards, and returns the stored destination address on completion. The existing forwarding unit still handles all single-cycle ALU hazards.

## Interface
- NUM_REGS, 32, architectural register count; x0 is never tracked
- ADDR_W, 5, register address width; must satisfy 2^ADDR_W >= NUM_REGS
- NUM_UNITS, 2, number of long-latency units (unit 0 = load, unit 1 = FFT)
- UNIT_W, 1, unit index width; must satisfy 2^UNIT_W >= NUM_UNITS
- TIMEOUT, 64, maximum busy cycles per unit; 0 disables the watchdog

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- id_valid  in  1  the decode stage holds a valid instruction
- id_rs1, id_rs2  in  ADDR_W  source register addresses
- id_rs1_used, id_rs2_used  in  1  the instruction reads that source
- id_rd  in  ADDR_W  destination register address
- id_rd_wena  in  1  the instruction writes id_rd
- id_long  in  1  the instruction targets a long-latency unit
- id_unit  in  UNIT_W  target unit index; valid when id_long=1
- flush  in  1  pipeline flush; suppresses issue this cycle
- cpl_valid  in  NUM_UNITS  one-cycle completion pulse per unit
- id_stall  out  1  hold PC and IF/ID, and insert a bubble into ID/EX
- issue  out  1  the decode-stage instruction advances this cycle
- pending  out  NUM_REGS  bit r set = a long write to r is outstanding
- unit_busy  out  NUM_UNITS  the unit holds an in-flight operation
- cpl_waddr  out  NUM_UNITS*ADDR_W  stored destination per unit; field u occupies bits [u*ADDR_W +: ADDR_W]
- err  out  1  sticky error flag
- err_code  out  2  first error seen: 01 = timeout, 10 = spurious completion

## Operation
- Per-unit state is a two-state FSM with states IDLE and BUSY. Each unit also holds a registered rd, a wena bit and a busy counter.
- Hazard terms are evaluated only against registered state:
  - RAW: (id_rs1_used & pending[id_rs1]) | (id_rs2_used & pending[id_rs2])
  - WAW: id_rd_wena & pending[id_rd]; applies to both short and long instructions
  - Structural: id_long & unit_busy[id_unit]
- Addresses equal to 0 never produce a hazard.
- id_stall = id_valid & (RAW | WAW | structural).
- issue = id_valid & ~id_stall & ~flush.
- When issue and id_long are both high, unit id_unit goes IDLE to BUSY and latches id_rd and id_rd_wena. pending[id_rd] is set only if id_rd_wena=1 and id_rd != 0.
- When cpl_valid[u] is high and unit u is BUSY:
  - the unit goes BUSY to IDLE;
  - its pending bit is cleared;
  - cpl_waddr field u holds the stored rd for that cycle, and keeps that value afterward.
- When cpl_valid[u] is high and unit u is IDLE, the pulse is ignored and the spurious-completion error is raised.
- A completion and a new issue to the same unit in the same cycle is impossible, because the structural term stalls the issue.
- A completion on unit a and an issue to unit b in the same cycle are both applied. Clearing the completed rd has lower priority than setting the new rd.
- Watchdog (TIMEOUT > 0): the counter resets on entry to BUSY and increments every BUSY cycle. When it reaches TIMEOUT-1 with no completion, the unit is forced to IDLE, its pending bit is cleared, and the timeout error is raised.
- err is set on the first error and cleared only by reset. err_code keeps the first error's code; when both errors occur in the same cycle, timeout wins.

## Timing
- Reset values: every output is 0, all units are IDLE, all counters are 0.
- Reset asserted mid-operation drops all outstanding state immediately, with no completion reported.
- id_stall and issue are combinational from the inputs and registered state; there is no added cycle.
- Issue of a long op in cycle t: pending and unit_busy are visible from cycle t+1, so a dependent instruction in cycle t+1 stalls.
- Completion in cycle c: the bit clears at the edge ending cycle c, so the dependent instruction issues in cycle c+1 at the earliest. There is no same-cycle bypass.
- flush does not clear in-flight units; older long ops still complete normally.

## Test plan
- Issue LW x5 (unit 0), then ADD x6,x5,x1 -> id_stall=1 until the cycle after cpl_valid[0]; cpl_waddr[4:0]=5; ADD issues in cycle c+1.
- Issue FFT x7 (unit 1), then LW x8 -> LW issues with no stall; the two completions arrive in either order, and pending returns to all zero after both.
- Issue FFT x7, then a second FFT op -> structural stall until completion; then ADDI x7 -> WAW stall when x7 is pending.
- Issue a long op with rd=x0 -> pending stays 0; unit_busy[u]=1; a following ADD x1,x0,x0 does not stall.
- TIMEOUT=8 with no completion -> after 8 busy cycles unit_busy=0, pending bit cleared, err=1, err_code=01; a later cpl_valid on that idle unit leaves err_code=01.
- Pulse rst low while both units are BUSY and flush is asserted -> all outputs read 0 asynchronously; the next issue after reset sees no hazards.
